xy_switch_alloc: RTL
====================

Name: xy_switch_alloc

Overview:
- Parametrised successor to the 5-port mesh router routing/arbitration stage. It sits between the five input buffers and five output buffers.
- Per cycle, it decodes the XY header in each input's head word and raises requests. A round-robin arbiter per output grants one request, and the block pops and pushes the winning word in the same cycle.
- New relative to the previous generation: configurable header layout, round-robin fairness with a registered pointer, hop-count decrement on forwarded words, discard of invalid heads, and saturating statistics counters.

Parameters:
DATA_W, 32, word width; each buffer word is a single-word packet carrying its own header.
HOP_W, 2, width of each hop field.
VALID_BIT, 16, header valid bit position.
XDIR_BIT, 15, X direction bit position (0 = out port 0, 1 = out port 1).
XHOP_LSB, 13, LSB of the X hop field.
YDIR_BIT, 12, Y direction bit position (0 = out port 2, 1 = out port 3).
YHOP_LSB, 10, LSB of the Y hop field.
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest input index wins.
CNT_W, 16, statistics counter width.

Ports:
clk  in  1  clock; single clock domain.
reset  in  1  synchronous, active-high reset.
in_dout  in  5*DATA_W  head words of input buffers 0..4; port p occupies [p*DATA_W +: DATA_W].
in_emptybar  in  5  1 = input buffer p is non-empty.
in_get  out  5  pop strobe to input buffer p.
out_fullbar  in  5  1 = output buffer q has space.
out_put  out  5  push strobe to output buffer q.
out_din  out  5*DATA_W  write data to output buffer q.
fwd_cnt  out  5*CNT_W  words pushed per output q.
drop_cnt  out  CNT_W  invalid heads discarded.

Behaviour:
- Reset is synchronous and active-high. While reset is high: in_get=0, out_put=0, out_din=0, counters=0, all RR pointers=0. A reset asserted mid-transfer suppresses any pop or push in that cycle.
- Route decode for input p, with head word h and in_emptybar[p]=1:
  - If h[VALID_BIT]=0: the word is a drop. Assert in_get[p] unconditionally, with no request and no push.
  - Else if xhop!=0: target is output XDIR (0 or 1).
  - Else if yhop!=0: target is output 2+YDIR.
  - Else: target is output 4 (PE eject).
- Request rule: req[p][q] = valid head && target==q && out_fullbar[q]. A full output raises no request, so the input holds.
- Arbitration, one arbiter per output q, combinational from req and ptr[q]:
  - RR_EN=1: search starts at input ptr[q] and wraps 4 to 0. The first requester wins.
  - RR_EN=0: the lowest requesting index wins.
  - At most one grant per output and at most one per input per cycle (an input targets exactly one output).
- Transfer: when grant[p][q]=1, in the same cycle assert in_get[p]=1 and out_put[q]=1, and drive out_din[q] with the modified word. Latency from grant to pop/push is 0 cycles. With no grant on q, out_din[q]=0 and out_put[q]=0.
- Hop update on out_din:
  - Target 0/1: the X hop field is decremented by 1.
  - Target 2/3: the Y hop field is decremented by 1.
  - Target 4: the word is unchanged.
  - All other bits pass unchanged. Decrement never underflows, because a decrement happens only when the field is nonzero.
- Pointer update, registered: on a clock edge where out_put[q]=1 from input p, ptr[q] <= (p+1) mod 5. Otherwise ptr[q] holds. With RR_EN=0, pointers stay 0.
- Counters are registered and saturate at all-ones:
  - fwd_cnt[q] increments on each out_put[q].
  - drop_cnt increments by the number of drops in the cycle (0..5), saturating.
- Simultaneous events: a drop on one input and grants on other inputs proceed in the same cycle. Contention on one output serves exactly one input; losers hold their head word and retry next cycle.
- A head with in_emptybar=0 is ignored regardless of content.

Test Plan:
- Input 0 head: valid=1, xdir=1, xhop=2, yhop=1; out_fullbar=11111 -> in_get[0]=1, out_put[1]=1, out_din[1] xhop=1 with other bits equal; fwd_cnt[1]=1 next cycle.
- Inputs 0, 1 and 4 all hold yhop=1, ydir=0, xhop=0, held for 6 cycles, RR_EN=1, ptr reset -> grants to output 2 in order 0,1,4,0,1,4. With RR_EN=0 -> input 0 is granted every cycle.
- Input 3 head: xhop=0, yhop=0, valid=1, with out_fullbar[4]=0 for 3 cycles then 1 -> no in_get/out_put for 3 cycles, then one push to output 4 with the word unmodified.
- Inputs 2 and 3 heads valid=0 in the same cycle as input 4 routing to output 0 -> in_get=11100, out_put=00001, drop_cnt=2 next cycle.
- Reset asserted in a cycle where a grant is pending -> in_get=0, out_put=0; next cycle counters=0, ptr=0, and arbitration restarts from input 0.
- With CNT_W=2, push to output 0 five times -> fwd_cnt[0] saturates at 3.

Source files
------------

// File: rtl/xy_switch_alloc_if.sv
// xy_switch_alloc_if: bundles the buffer-side signals of the XY switch allocator.
//   in_dout     : head words of the five input buffers, port p at [p*DATA_W +: DATA_W]
//   in_emptybar : input buffer p non-empty
//   in_get      : pop strobe to input buffer p
//   out_fullbar : output buffer q has space
//   out_put     : push strobe to output buffer q
//   out_din     : write data to output buffer q, port q at [q*DATA_W +: DATA_W]
//   fwd_cnt     : saturating words-forwarded counter per output, q at [q*CNT_W +: CNT_W]
//   drop_cnt    : saturating count of discarded invalid heads
// The slave modport is the allocator; the master modport is the buffer side.
interface xy_switch_alloc_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [5*DATA_W-1:0] in_dout;
  logic [4:0]          in_emptybar;
  logic [4:0]          in_get;
  logic [4:0]          out_fullbar;
  logic [4:0]          out_put;
  logic [5*DATA_W-1:0] out_din;
  logic [5*CNT_W-1:0]  fwd_cnt;
  logic [CNT_W-1:0]    drop_cnt;

  modport master (
    output in_dout, in_emptybar, out_fullbar,
    input  in_get, out_put, out_din, fwd_cnt, drop_cnt
  );

  modport slave (
    input  in_dout, in_emptybar, out_fullbar,
    output in_get, out_put, out_din, fwd_cnt, drop_cnt
  );
endinterface

// File: rtl/xy_switch_alloc.sv
// xy_switch_alloc: routing/arbitration stage of a 5-port XY mesh router.
// Each cycle it decodes the XY header of every input head word, raises one
// request per valid head towards its target output (only if that output has
// space), arbitrates each output round-robin (or fixed priority), and pops
// the winning input / pushes the hop-decremented word in the same cycle.
// Invalid heads are popped and discarded. Saturating statistics count
// forwarded words per output and discarded heads.
// Ports:
//   clk   : single clock
//   reset : synchronous active-high reset
//   bus   : xy_switch_alloc_if.slave (buffer-side handshake, data, statistics)
module xy_switch_alloc #(
  parameter int DATA_W    = 32,
  parameter int HOP_W     = 2,
  parameter int VALID_BIT = 16,
  parameter int XDIR_BIT  = 15,
  parameter int XHOP_LSB  = 13,
  parameter int YDIR_BIT  = 12,
  parameter int YHOP_LSB  = 10,
  parameter bit RR_EN     = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               reset,
  xy_switch_alloc_if.slave  bus
);

  localparam int NP = 5;

  logic [NP-1:0][DATA_W-1:0] head_s;
  logic [NP-1:0][DATA_W-1:0] mod_word_s;
  logic [NP-1:0][2:0]        target_s;
  logic [NP-1:0]             valid_head_s;
  logic [NP-1:0]             drop_s;
  logic [NP-1:0][NP-1:0]     req_s;       // [q][p]
  logic [NP-1:0][2:0]        win_s;       // winning input per output
  logic [NP-1:0]             win_any_s;
  logic [NP-1:0][2:0]        start_s;
  logic [3:0]                idx_s;
  logic [NP-1:0]             in_get_s;
  logic [NP-1:0]             out_put_s;
  logic [NP-1:0][DATA_W-1:0] out_din_s;
  logic [2:0]                ndrop_s;
  logic [CNT_W+2:0]          drop_sum_s;

  logic [NP-1:0][2:0]        ptr_r;
  logic [NP-1:0][CNT_W-1:0]  fwd_cnt_r;
  logic [CNT_W-1:0]          drop_cnt_r;

  // Header decode: drop detection, target output and hop-updated word per input
  always_comb begin
    head_s       = '0;
    mod_word_s   = '0;
    target_s     = '0;
    valid_head_s = '0;
    drop_s       = '0;
    for (int p = 0; p < NP; p++) begin
      head_s[p]       = bus.in_dout[p*DATA_W +: DATA_W];
      valid_head_s[p] = bus.in_emptybar[p] & head_s[p][VALID_BIT];
      drop_s[p]       = bus.in_emptybar[p] & ~head_s[p][VALID_BIT];
      // X is resolved before Y; both hops zero means eject to the PE port
      if (head_s[p][XHOP_LSB +: HOP_W] != {HOP_W{1'b0}}) begin
        target_s[p] = {2'b00, head_s[p][XDIR_BIT]};
      end else if (head_s[p][YHOP_LSB +: HOP_W] != {HOP_W{1'b0}}) begin
        target_s[p] = 3'd2 + {2'b00, head_s[p][YDIR_BIT]};
      end else begin
        target_s[p] = 3'd4;
      end
      // The decremented field is nonzero by construction, so no underflow
      mod_word_s[p] = head_s[p];
      case (target_s[p])
        3'd0, 3'd1: mod_word_s[p][XHOP_LSB +: HOP_W] = head_s[p][XHOP_LSB +: HOP_W] - HOP_W'(1'b1);
        3'd2, 3'd3: mod_word_s[p][YHOP_LSB +: HOP_W] = head_s[p][YHOP_LSB +: HOP_W] - HOP_W'(1'b1);
        default:    mod_word_s[p] = head_s[p];
      endcase
    end
  end

  // Request matrix: a full output raises no request so its inputs simply hold
  always_comb begin
    req_s = '0;
    for (int q = 0; q < NP; q++) begin
      for (int p = 0; p < NP; p++) begin
        req_s[q][p] = valid_head_s[p] & (target_s[p] == 3'(q)) & bus.out_fullbar[q];
      end
    end
  end

  // Per-output arbiter: scan from the pointer (or from 0) wrapping 4 -> 0
  always_comb begin
    win_s     = '0;
    win_any_s = '0;
    start_s   = '0;
    idx_s     = 4'd0;
    for (int q = 0; q < NP; q++) begin
      if (RR_EN) begin
        start_s[q] = ptr_r[q];
      end else begin
        start_s[q] = 3'd0;
      end
      for (int k = 0; k < NP; k++) begin
        idx_s = {1'b0, start_s[q]} + 4'(k);
        if (idx_s >= 4'd5) begin
          idx_s = idx_s - 4'd5;
        end else begin
          idx_s = idx_s;
        end
        if (!win_any_s[q] && req_s[q][idx_s[2:0]]) begin
          win_any_s[q] = 1'b1;
          win_s[q]     = idx_s[2:0];
        end else begin
          win_any_s[q] = win_any_s[q];
        end
      end
    end
  end

  // Transfer strobes and data; reset suppresses every pop and push
  always_comb begin
    in_get_s  = '0;
    out_put_s = '0;
    out_din_s = '0;
    if (reset) begin
      in_get_s  = '0;
      out_put_s = '0;
      out_din_s = '0;
    end else begin
      for (int q = 0; q < NP; q++) begin
        if (win_any_s[q]) begin
          out_put_s[q]           = 1'b1;
          out_din_s[q]           = mod_word_s[win_s[q]];
          in_get_s[win_s[q]]     = 1'b1;
        end else begin
          out_din_s[q] = {DATA_W{1'b0}};
        end
      end
      in_get_s = in_get_s | drop_s;
    end
  end

  // Number of heads discarded this cycle
  always_comb begin
    ndrop_s = 3'd0;
    for (int p = 0; p < NP; p++) begin
      ndrop_s = ndrop_s + {2'b00, drop_s[p]};
    end
    drop_sum_s = {3'b000, drop_cnt_r} + (CNT_W+3)'(ndrop_s);
  end

  // Round-robin pointers: next search starts just after the last winner
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= '0;
    end else begin
      for (int q = 0; q < NP; q++) begin
        if (RR_EN && out_put_s[q]) begin
          ptr_r[q] <= (win_s[q] == 3'd4) ? 3'd0 : win_s[q] + 3'd1;
        end else begin
          ptr_r[q] <= ptr_r[q];
        end
      end
    end
  end

  // Saturating forwarded-word counters, one per output
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_cnt_r <= '0;
    end else begin
      for (int q = 0; q < NP; q++) begin
        if (out_put_s[q] && (fwd_cnt_r[q] != {CNT_W{1'b1}})) begin
          fwd_cnt_r[q] <= fwd_cnt_r[q] + CNT_W'(1'b1);
        end else begin
          fwd_cnt_r[q] <= fwd_cnt_r[q];
        end
      end
    end
  end

  // Saturating drop counter; several drops may land in one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_r <= '0;
    end else if (drop_sum_s > {3'b000, {CNT_W{1'b1}}}) begin
      drop_cnt_r <= {CNT_W{1'b1}};
    end else begin
      drop_cnt_r <= drop_sum_s[CNT_W-1:0];
    end
  end

  assign bus.in_get   = in_get_s;
  assign bus.out_put  = out_put_s;
  assign bus.out_din  = out_din_s;
  assign bus.fwd_cnt  = fwd_cnt_r;
  assign bus.drop_cnt = drop_cnt_r;

endmodule
